// File: rtl/uart_send.sv
// uart_send: 8N1 UART transmitter with a 4-entry byte FIFO.
module uart_send #(
  parameter int CLK_FREQ = 12000000,
  parameter int UART_BPS = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ovf,
  output logic       uart_txd
);
  localparam logic [15:0] BPS_CNT = 16'(CLK_FREQ / UART_BPS);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [4];
  logic [7:0] mem_d [4];
  logic [1:0] wr_q, wr_d, rd_q, rd_d;
  logic [2:0] count_q, count_d, bit_q, bit_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [7:0] sh_q, sh_d;
  logic txd_q, txd_d, ovf_q, ovf_d;
  logic push, pop, bit_end;
  always_comb begin
    bit_end = clk_cnt_q == BPS_CNT - 16'd1;
    push = tx_req && count_q != 3'd4;
    pop = count_q != 3'd0 && (state_q == IDLE || (state_q == STOP && bit_end));
    ovf_d = tx_req && count_q == 3'd4;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = tx_data;
    wr_d = wr_q + {1'b0, push};
    rd_d = rd_q + {1'b0, pop};
    count_d = count_q + {2'b0, push} - {2'b0, pop};
    clk_cnt_d = (state_q == IDLE || bit_end) ? 16'd0 : clk_cnt_q + 16'd1;
    state_d = state_q;
    bit_d = bit_q;
    sh_d = sh_q;
    txd_d = txd_q;
    case (state_q)
      IDLE: begin
        txd_d = !pop;
        bit_d = 3'd0;
        if (pop) begin
          state_d = START;
          sh_d = mem_q[rd_q];
        end
      end
      START: if (bit_end) begin
        state_d = DATA;
        txd_d = sh_q[0];
        bit_d = 3'd0;
      end
      DATA: if (bit_end) begin
        if (bit_q == 3'd7) begin
          state_d = STOP;
          txd_d = 1'b1;
        end else begin
          bit_d = bit_q + 3'd1;
          sh_d = sh_q >> 1;
          txd_d = sh_q[1];
        end
      end
      STOP: if (bit_end) begin
        // Next queued byte starts its start bit on this same edge: no idle gap.
        state_d = pop ? START : IDLE;
        txd_d = !pop;
        if (pop) sh_d = mem_q[rd_q];
      end
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      bit_q <= '0;
      clk_cnt_q <= '0;
      sh_q <= '0;
      txd_q <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      bit_q <= bit_d;
      clk_cnt_q <= clk_cnt_d;
      sh_q <= sh_d;
      txd_q <= txd_d;
      ovf_q <= ovf_d;
    end
  end
  assign tx_ready = count_q != 3'd4;
  assign tx_busy = state_q != IDLE || count_q != 3'd0;
  assign tx_done = state_q == STOP && bit_end;
  assign tx_ovf = ovf_q;
  assign uart_txd = txd_q;
endmodule

// File: tb/tb_uart_send.sv
// tb_uart_send: directed bench for uart_send with a 10-clock bit period.
module tb_uart_send;
  localparam int BPS = 10;
  localparam int FL = 10 * BPS;
  logic clk = 1'b0;
  logic rst_n, tx_req, tx_ready, tx_busy, tx_done, tx_ovf, txd;
  logic [7:0] tx_data;
  logic [7:0] tx_q[$];
  int total = 0;
  int bad = 0;

  uart_send #(.CLK_FREQ(160), .UART_BPS(16)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .tx_req(tx_req), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_ovf(tx_ovf),
    .uart_txd(txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [7:0] b);
    tx_req = 1'b1;
    tx_data = b;
    @(negedge clk);
    tx_req = 1'b0;
  endtask

  // k indexes the sample taken after edge E0+1+k, E0 being the first accepted push.
  task automatic check_line(input string tag, input int off);
    int n, bad_bits, dn, bad_dn, ov, f, b;
    logic eb;
    n = tx_q.size();
    bad_bits = 0; dn = 0; bad_dn = 0; ov = 0;
    for (int k = off; k < n * FL; k++) begin
      tx_data = 8'($urandom);
      @(negedge clk);
      f = k / FL;
      b = (k % FL) / BPS;
      eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : tx_q[f][b-1];
      if (txd !== eb) bad_bits++;
      if (tx_done) begin
        dn++;
        if (k % FL != FL - 1) bad_dn++;
      end
      if (tx_ovf) ov++;
    end
    chk({tag, "_bits"}, bad_bits, 0);
    chk({tag, "_done_n"}, dn, n);
    chk({tag, "_done_pos"}, bad_dn, 0);
    chk({tag, "_ovf"}, ov, 0);
    @(negedge clk);
    chk({tag, "_busy_after"}, tx_busy, 0);
    chk({tag, "_txd_after"}, txd, 1);
    tx_q.delete();
  endtask

  initial begin
    int viol;
    rst_n = 1'b0;
    tx_req = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_ovf", tx_ovf, 0);
    rst_n = 1'b1;

    viol = 0;
    repeat (500) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_ovf !== 1'b0) viol++;
    end
    chk("idle_viol", viol, 0);

    push1(8'h55);
    chk("single_e0_txd", txd, 1);
    chk("single_e0_busy", tx_busy, 1);
    tx_q.push_back(8'h55);
    check_line("single", 0);

    tx_req = 1'b1;
    tx_data = 8'hA5;
    @(negedge clk);
    tx_data = 8'h3C;
    @(negedge clk);
    tx_req = 1'b0;
    chk("b2b_start", txd, 0);
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h3C);
    check_line("b2b", 1);

    for (int i = 0; i < 6; i++) begin
      tx_data = 8'(i + 1);
      tx_req = 1'b1;
      if (i == 4) chk("ovf_ready_before_full", tx_ready, 1);
      if (i == 5) chk("ovf_ready_full", tx_ready, 0);
      @(negedge clk);
    end
    tx_req = 1'b0;
    chk("ovf_pulse", tx_ovf, 1);
    for (int i = 1; i <= 5; i++) tx_q.push_back(8'(i));
    check_line("ovf", 5);

    push1(8'h81);
    tx_q.push_back(8'h81);
    check_line("stab", 0);

    tx_req = 1'b1;
    tx_data = 8'hFF;
    @(negedge clk);
    tx_data = 8'h12;
    @(negedge clk);
    tx_data = 8'h34;
    @(negedge clk);
    tx_req = 1'b0;
    repeat (4 * BPS + 1) @(negedge clk);
    chk("midrst_busy_before", tx_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_txd", txd, 1);
    chk("midrst_busy", tx_busy, 0);
    chk("midrst_done", tx_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    viol = 0;
    repeat (30 * BPS) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) viol++;
    end
    chk("midrst_after_viol", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
